// File: rtl/axi_playback_rd_engine_if.sv
// AXI4 read-only channel bundle (AR + R) between the playback engine and memory.
// The engine drives the address channel through the master modport; memory responds through slave.
interface axi_playback_rd_engine_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rlast;

    modport master (
        output arvalid,
        output araddr,
        input  arready,
        input  rdata,
        input  rvalid,
        input  rlast
    );

    modport slave (
        input  arvalid,
        input  araddr,
        output arready,
        output rdata,
        output rvalid,
        output rlast
    );
endinterface

// File: rtl/axi_playback_rd_engine.sv
// Segment-table playback engine: records segment end addresses, then replays a chosen
// segment as back-to-back AXI read bursts, optionally looping, with a registered beat stream.
module axi_playback_rd_engine #(
    parameter int MEM_ROW_WIDTH    = 15,
    parameter int MEM_COLUMN_WIDTH = 10,
    parameter int MEM_BANK_WIDTH   = 3,
    parameter int CTRL_ADDR_WIDTH  = MEM_ROW_WIDTH + MEM_BANK_WIDTH + MEM_COLUMN_WIDTH,
    parameter int DQ_WIDTH         = 32,
    parameter int BURST_LEN        = 16,
    parameter int SEG_NUM          = 8,
    localparam int SEG_W           = $clog2(SEG_NUM),
    localparam int CNT_W           = SEG_W + 1,
    localparam int BEAT_W          = DQ_WIDTH * 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rec_end,
    input  logic [CTRL_ADDR_WIDTH-1:0] rec_end_addr,
    input  logic                       tbl_clear,
    input  logic                       play_start,
    input  logic [SEG_W-1:0]           play_seg,
    input  logic                       play_loop,
    input  logic                       play_stop,
    axi_playback_rd_engine_if.master   axi,
    input  logic                       sink_afull,
    output logic                       out_valid,
    output logic [BEAT_W-1:0]          out_data,
    output logic                       busy,
    output logic [CNT_W-1:0]           seg_count,
    output logic                       play_done,
    output logic                       cmd_err
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_STEP = CTRL_ADDR_WIDTH'(BURST_LEN * 8);

    state_t                     state_q;
    logic                       active_q;
    logic                       loop_q;
    logic                       stop_q;
    logic [CNT_W-1:0]           seg_count_q;
    logic [CTRL_ADDR_WIDTH-1:0] cur_addr_q;
    logic [CTRL_ADDR_WIDTH-1:0] end_addr_q;
    logic [CTRL_ADDR_WIDTH-1:0] start_addr_q;
    logic                       arvalid_q;
    logic [CTRL_ADDR_WIDTH-1:0] araddr_q;
    logic                       out_valid_q;
    logic [BEAT_W-1:0]          out_data_q;
    logic                       play_done_q;
    logic                       cmd_err_q;

    // bound_rd[i] holds bound[i+1]; bound[0] is the constant zero and has no storage.
    logic [CTRL_ADDR_WIDTH-1:0] bound_rd [SEG_NUM];
    logic                       tbl_full;
    logic                       bound_we;
    logic [SEG_W-1:0]           seg_prev;
    logic [CTRL_ADDR_WIDTH-1:0] start_bound;
    logic [CTRL_ADDR_WIDTH-1:0] stop_bound;
    logic                       seg_ok;
    logic                       stop_now;

    assign tbl_full = (seg_count_q >= CNT_W'(SEG_NUM));
    assign bound_we = rec_end && !tbl_clear && !tbl_full;
    assign seg_ok   = ({1'b0, play_seg} < seg_count_q);
    assign stop_now = stop_q || play_stop;

    genvar gi;
    generate
        for (gi = 0; gi < SEG_NUM; gi++) begin : g_bound
            logic [CTRL_ADDR_WIDTH-1:0] entry_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_q <= '0;
                end else if (bound_we && (seg_count_q[SEG_W-1:0] == SEG_W'(gi))) begin
                    entry_q <= rec_end_addr;
                end
            end
            assign bound_rd[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        seg_prev    = play_seg - 1'b1;
        start_bound = '0;
        if (play_seg != '0) begin
            start_bound = bound_rd[seg_prev];
        end
        stop_bound = bound_rd[play_seg];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            active_q     <= 1'b0;
            loop_q       <= 1'b0;
            stop_q       <= 1'b0;
            seg_count_q  <= '0;
            cur_addr_q   <= '0;
            end_addr_q   <= '0;
            start_addr_q <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            play_done_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            play_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            out_valid_q <= 1'b0;

            // A clear in the same cycle as rec_end swallows the record, even when the clear itself is refused.
            if (tbl_clear) begin
                if (busy) cmd_err_q   <= 1'b1;
                else      seg_count_q <= '0;
            end else if (rec_end) begin
                if (tbl_full) cmd_err_q   <= 1'b1;
                else          seg_count_q <= seg_count_q + 1'b1;
            end

            if (play_start) begin
                if (!busy && seg_ok) begin
                    cur_addr_q   <= start_bound;
                    end_addr_q   <= stop_bound;
                    start_addr_q <= start_bound;
                    loop_q       <= play_loop;
                    stop_q       <= 1'b0;
                    if (start_bound < stop_bound) active_q    <= 1'b1;
                    else                          play_done_q <= 1'b1;
                end else begin
                    cmd_err_q <= 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (play_stop && active_q) begin
                        active_q <= 1'b0;
                    end else if (active_q && (cur_addr_q < end_addr_q) && !sink_afull) begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (play_stop) stop_q <= 1'b1;
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= cur_addr_q;
                    end else if (axi.arready) begin
                        arvalid_q  <= 1'b0;
                        cur_addr_q <= cur_addr_q + ADDR_STEP;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (play_stop) stop_q <= 1'b1;
                    out_valid_q <= axi.rvalid;
                    if (axi.rvalid) begin
                        out_data_q <= axi.rdata;
                        if (axi.rlast) begin
                            state_q <= S_IDLE;
                            // A pending stop ends playback quietly; otherwise a finished segment loops or completes.
                            if (stop_now) begin
                                active_q <= 1'b0;
                                stop_q   <= 1'b0;
                            end else if (cur_addr_q >= end_addr_q) begin
                                if (loop_q) begin
                                    cur_addr_q <= start_addr_q;
                                end else begin
                                    active_q    <= 1'b0;
                                    play_done_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = active_q || (state_q != S_IDLE);
    assign seg_count   = seg_count_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign play_done   = play_done_q;
    assign cmd_err     = cmd_err_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
endmodule

// File: doc/axi_playback_rd_engine.md
AXI_PLAYBACK_RD_ENGINE -- requirements
Module: axi_playback_rd_engine

Interface
REQ-001 SHALL have parameters: MEM_ROW_WIDTH, 15, DRAM row bits; MEM_COLUMN_WIDTH, 10, column bits; MEM_BANK_WIDTH, 3, bank bits; CTRL_ADDR_WIDTH, row+bank+column, AXI address width; DQ_WIDTH, 32, DRAM data width (AXI beat = DQ_WIDTH*8); BURST_LEN, 16, beats per burst; SEG_NUM, 8, segment table depth (power of 2, ≥2).
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-low reset.
- rec_end  in  1  one-cycle pulse: the current recording segment has ended.
- rec_end_addr  in  CTRL_ADDR_WIDTH  write address at segment end, sampled with rec_end.
- tbl_clear  in  1  pulse: empty the segment table.
- play_start  in  1  pulse: begin playback of play_seg.
- play_seg  in  clog2(SEG_NUM)  segment index, sampled with play_start.
- play_loop  in  1  loop mode, sampled with play_start.
- play_stop  in  1  pulse: stop playback.
- axi_arvalid / axi_arready / axi_araddr  out/in/out  1/1/CTRL_ADDR_WIDTH  AXI read address channel.
- axi_rdata / axi_rvalid / axi_rlast  in  DQ_WIDTH*8/1/1  AXI read data channel.
- sink_afull  in  1  downstream buffer cannot take another burst.
- out_valid / out_data  out  1/DQ_WIDTH*8  playback beat stream.
- busy  out  1  playback active or burst outstanding.
- seg_count  out  clog2(SEG_NUM)+1  stored segments.
- play_done  out  1  one-cycle pulse: non-looped segment completed.
- cmd_err  out  1  one-cycle pulse: command rejected.

Function
REQ-003 SHALL keep boundary table bound[0..SEG_NUM]; bound[0]=0 permanently; segment i spans [bound[i], bound[i+1]).
REQ-004 On rec_end with seg_count<SEG_NUM, SHALL write bound[seg_count+1]=rec_end_addr and increment seg_count next cycle; with seg_count=SEG_NUM SHALL ignore write and pulse cmd_err.
REQ-005 tbl_clear SHALL zero seg_count when busy=0; when busy=1 SHALL be ignored and pulse cmd_err; tbl_clear and rec_end same cycle: clear wins.
REQ-006 play_start with busy=0 and play_seg<seg_count SHALL load cur_addr=bound[play_seg], end_addr=bound[play_seg+1], latch loop flag, set active; otherwise SHALL pulse cmd_err and change nothing.
REQ-007 A started segment with bound[play_seg]>=bound[play_seg+1] SHALL pulse play_done one cycle later, issue no read, leave active=0.
REQ-008 State machine IDLE, ADDR, DATA; IDLE->ADDR when active, cur_addr<end_addr, sink_afull=0; ADDR->DATA on arvalid&arready; DATA->IDLE on rvalid&rlast.
REQ-009 axi_arvalid SHALL assert the cycle after entering ADDR, hold with axi_araddr=cur_addr stable until arready, deassert the cycle after handshake.
REQ-010 On handshake cur_addr SHALL advance by BURST_LEN*8, modulo 2^CTRL_ADDR_WIDTH.
REQ-011 out_valid/out_data SHALL be axi_rvalid/axi_rdata registered, latency exactly 1 cycle; out_valid=0 outside DATA.
REQ-012 On DATA->IDLE with cur_addr>=end_addr: loop=1 SHALL reload cur_addr=bound of latched segment and continue; loop=0 SHALL clear active and pulse play_done coincident with IDLE entry.
REQ-013 play_stop in IDLE SHALL clear active next cycle; in ADDR or DATA SHALL complete outstanding address/burst, then clear active; play_done SHALL NOT pulse on stop; stop during ADDR still completes the address handshake.
REQ-014 busy SHALL equal active OR state≠IDLE.
REQ-015 sink_afull SHALL only gate IDLE->ADDR; an issued burst SHALL never be throttled.

Reset
REQ-016 rst low SHALL asynchronously force state=IDLE, active=0, seg_count=0, cur_addr=end_addr=0, axi_arvalid=0, axi_araddr=0, out_valid=0, out_data=0, play_done=0, cmd_err=0, all bound entries=0.
REQ-017 Reset mid-burst SHALL abandon the burst; remaining rvalid beats after release SHALL NOT produce out_valid.

Verification
REQ-018 Record: rec_end with addr 0x800, then 0x1000 -> seg_count=2, bound[1]=0x800, bound[2]=0x1000.
REQ-019 Play seg 1, BURST_LEN=16, arready always 1 -> araddr 0x800, 0x880, ..., 0xF80 (16 bursts), 256 out_valid beats each 1 cycle after rvalid, one play_done.
REQ-020 Loop seg 0 (0..0x800), play_stop during 3rd burst's DATA -> 3rd burst finishes, no 4th arvalid, busy falls, no play_done.
REQ-021 sink_afull=1 while active -> arvalid stays 0; release -> arvalid within 2 cycles.
REQ-022 play_seg=5 with seg_count=2, and play_start while busy -> cmd_err pulse, state unchanged; SEG_NUM+1 rec_end pulses -> seg_count=SEG_NUM, final pulse cmd_err.
REQ-023 rst low during ADDR with arvalid=1 -> arvalid=0 immediately, seg_count=0, busy=0.
